// File: rtl/group_fill_gen.sv
// Grouped occupancy producer: fills the addressed group one bit per clock,
// thermometer order, and publishes registered per-group full flags.
//
// state  | meaning
// IDLE   | ready for a request; bad requests are rejected with err
// FILL   | setting the lowest clear bit of grp each cycle until rem hits 0
// DONE   | fill finished; done/err (err = overflow) register on the exit edge
module group_fill_gen #(
   parameter int GROUPS = 3,
   parameter int GW     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             req_grp,
   input  logic [2:0]             req_cnt,
   input  logic                   clr,
   output logic [GROUPS*GW-1:0]   occ,
   output logic [GROUPS-1:0]      full,
   output logic                   done,
   output logic                   err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FILL = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]           state, state_nxt;
   logic [1:0]           grp, grp_nxt;
   logic [2:0]           rem, rem_nxt;
   logic                 ovf, ovf_nxt;
   logic                 done_nxt, err_nxt;
   logic [GROUPS*GW-1:0] occ_nxt;
   logic [GROUPS-1:0]    full_nxt;
   logic [GW-1:0]        grp_word, grp_set;

   assign req_ready = (state == S_IDLE);

   always_comb begin
      state_nxt = state;
      grp_nxt   = grp;
      rem_nxt   = rem;
      ovf_nxt   = ovf;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      occ_nxt   = occ;
      grp_word  = '0;
      for (int g = 0; g < GROUPS; g++) begin
         if (int'(grp) == g) grp_word = occ[g*GW +: GW];
      end
      // x | (x+1) sets exactly the lowest clear bit of a thermometer word
      grp_set = grp_word | (grp_word + GW'(1));

      case (state)
         S_IDLE: begin
            if (req_valid) begin
               if (int'(req_grp) >= GROUPS || req_cnt == 3'd0 || int'(req_cnt) > GW) begin
                  err_nxt = 1'b1;
               end else begin
                  grp_nxt   = req_grp;
                  rem_nxt   = req_cnt;
                  ovf_nxt   = 1'b0;
                  state_nxt = S_FILL;
               end
            end
         end
         S_FILL: begin
            if (&grp_word) begin
               ovf_nxt   = 1'b1;
               state_nxt = S_DONE;
            end else begin
               for (int g = 0; g < GROUPS; g++) begin
                  if (int'(grp) == g) occ_nxt[g*GW +: GW] = grp_set;
               end
               rem_nxt = rem - 3'd1;
               if (rem == 3'd1) begin
                  ovf_nxt   = 1'b0;
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            done_nxt  = 1'b1;
            err_nxt   = ovf;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      full_nxt = '0;
      for (int g = 0; g < GROUPS; g++) begin
         full_nxt[g] = &occ_nxt[g*GW +: GW];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         grp   <= '0;
         rem   <= '0;
         ovf   <= 1'b0;
         occ   <= '0;
         full  <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else if (clr) begin
         state <= S_IDLE;
         grp   <= '0;
         rem   <= '0;
         ovf   <= 1'b0;
         occ   <= '0;
         full  <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         grp   <= grp_nxt;
         rem   <= rem_nxt;
         ovf   <= ovf_nxt;
         occ   <= occ_nxt;
         full  <= full_nxt;
         done  <= done_nxt;
         err   <= err_nxt;
      end
   end

endmodule
